freq_meter: RTL and testbench
=============================

// Module: freq_meter
// PURPOSE
//   Measures the period, and optionally the high time, of a slow square wave
//   `sig_in`, in clk_in cycles. sig_in is asynchronous, e.g. a divided clock,
//   a button line or an external oscillator.
//   Counterpart to the clock dividers: it recovers the divide ratio of a
//   generated clock. It provides self-check and rate readout for the button/
//   display path.
//   Back-to-back measurement: every rising edge both ends one period and
//   starts the next.
// PARAMETERS
//   CNT_W        26        width of the period/high-time counters and outputs
//   TIMEOUT      27000000  maximum measurable period in clk_in cycles
//                          (1 s at 27 MHz); 2 <= TIMEOUT <= 2**CNT_W-1
//   SYNC_STAGES  2         synchronizer flops on sig_in (>= 2)
// PORTS
//   clk_in     in   1      system clock
//   reset      in   1      asynchronous, active-high reset
//   sig_in     in   1      asynchronous input waveform
//   enable     in   1      1 = measure, 0 = return to IDLE
//   period     out  CNT_W  last measured period in clk_in cycles
//   high_time  out  CNT_W  high cycles within last period (see CONFIGURATION)
//   valid      out  1      1-cycle pulse when period/high_time update
//   timeout    out  1      level: no rising edge within TIMEOUT cycles
//   busy       out  1      1 while state is MEASURE
// BEHAVIOUR
//   - Reset: state=IDLE; period, high_time, valid, timeout and busy = 0;
//     sync chain and counters = 0. Reset is honoured mid-measurement.
//   - Sync: sig_in passes through SYNC_STAGES flops to give s. s_prev is s
//     delayed by one cycle. rise = s & ~s_prev.
//   - Edge latency: sig_in 0->1 produces rise SYNC_STAGES+1 cycles later.
//   - Counters:
//     - cnt counts clk_in cycles since the last rise.
//     - hcnt counts cycles with s=1 since the last rise.
//     - Both are loaded with 1 on a rise and increment in MEASURE.
//     - Neither counter can wrap: TIMEOUT bounds both.
//   - FSM:
//     IDLE:    enable=1 -> ARM. Counters are held at 0.
//     ARM:     wait for rise. On rise, cnt=hcnt=1, go to MEASURE. No valid.
//     MEASURE: on rise, period<=cnt and high_time<=hcnt; valid=1 the next
//              cycle; timeout<=0; cnt=hcnt=1; stay in MEASURE.
//              No rise and cnt==TIMEOUT -> timeout<=1, go to ARM.
//              period and high_time keep their old values.
//     any:     enable=0 -> IDLE next cycle. valid is forced 0. timeout is
//              cleared. period and high_time hold their last values.
//   - Simultaneous events:
//     - A rise in the same cycle that cnt==TIMEOUT is a valid measurement
//       with period=TIMEOUT. No timeout is raised.
//     - enable=0 takes priority over a rise in the same cycle.
//   - valid: high exactly 1 cycle per measurement. period and high_time are
//     stable from the cycle valid rises until the next valid.
//   - busy: equals (state==MEASURE).
// CONFIGURATION
//   FREQ_METER_DUTY_EN defined:
//     hcnt is implemented and high_time reports high cycles per period.
//   FREQ_METER_DUTY_EN undefined:
//     hcnt is not built. high_time is tied to 0. All other behaviour is
//     identical.
// TESTING
//   1. sig_in from a /10 divider, 5 high / 5 low, enable=1:
//      -> first valid after 2nd rise; period=10, high_time=5; valid pulses
//         every 10 cycles.
//   2. sig_in 3 high / 7 low:
//      -> period=10, high_time=3 (0 if FREQ_METER_DUTY_EN undefined).
//   3. TIMEOUT=100, sig_in stuck after one rise:
//      -> timeout=1 at 100 cycles after the rise, state ARM, period
//         unchanged. Resume a 20-cycle wave -> timeout=0 on first valid,
//         period=20.
//   4. TIMEOUT=100, rises exactly 100 cycles apart:
//      -> period=100, valid=1, timeout stays 0.
//   5. enable=0 mid-period, then 1:
//      -> IDLE, no valid, outputs hold. Re-arm needs 2 rises before the next
//         valid.
//   6. reset pulse mid-MEASURE:
//      -> all outputs 0 immediately (async). After release, valid only after
//         two new rises.

Source files
------------

// File: rtl/freq_meter.sv
// Measures the period (and, with FREQ_METER_DUTY_EN defined, the high time) of an
// asynchronous square wave in clk_in cycles; every rising edge ends one period and starts the next.
module freq_meter #(
   parameter int CNT_W       = 26,
   parameter int TIMEOUT     = 27000000,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             sig_in,
   input  logic             enable,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             valid,
   output logic             timeout,
   output logic             busy
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ARM     = 2'd1;
   localparam logic [1:0] MEASURE = 2'd2;

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_sPrev;
   logic [1:0]             r_state;
   logic [CNT_W-1:0]       r_cnt;
   logic [CNT_W-1:0]       r_period;
   logic                   r_valid;
   logic                   r_timeout;

   logic w_s;
   logic w_rise;
   logic w_atLimit;
   logic w_load;
   logic w_meas;
   logic w_clr;

   // Synchronizer chain plus one extra flop for edge detection.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         r_sync  <= '0;
         r_sPrev <= 1'b0;
      end else begin
         r_sync  <= {r_sync[SYNC_STAGES-2:0], sig_in};
         r_sPrev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign w_s       = r_sync[SYNC_STAGES-1];
   assign w_rise    = w_s & ~r_sPrev;
   assign w_atLimit = (r_cnt == TIMEOUT_C);

   // A rise wins over the limit, so a period of exactly TIMEOUT is a valid measurement.
   assign w_load = enable && ((r_state == ARM) || (r_state == MEASURE)) && w_rise;
   assign w_meas = enable && (r_state == MEASURE) && w_rise;
   assign w_clr  = !enable || (r_state == IDLE) || ((r_state == ARM) && !w_rise)
                 || ((r_state == MEASURE) && !w_rise && w_atLimit);

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_period  <= '0;
         r_valid   <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_valid <= w_meas;

         if (w_clr)
            r_cnt <= '0;
         else if (w_load)
            r_cnt <= ONE_C;
         else
            r_cnt <= r_cnt + ONE_C;

         if (w_meas) begin
            r_period  <= r_cnt;
            r_timeout <= 1'b0;
         end

         if (!enable) begin
            r_state   <= IDLE;
            r_timeout <= 1'b0;
         end else begin
            case (r_state)
               IDLE:    r_state <= ARM;
               ARM:     if (w_rise) r_state <= MEASURE;
               MEASURE: begin
                  if (!w_rise && w_atLimit) begin
                     r_timeout <= 1'b1;
                     r_state   <= ARM;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

`ifdef FREQ_METER_DUTY_EN
   logic [CNT_W-1:0] r_hcnt;
   logic [CNT_W-1:0] r_highTime;

   // High-time counter shares the load/clear timing of the period counter.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         r_hcnt     <= '0;
         r_highTime <= '0;
      end else begin
         if (w_clr)
            r_hcnt <= '0;
         else if (w_load)
            r_hcnt <= ONE_C;
         else if (w_s)
            r_hcnt <= r_hcnt + ONE_C;

         if (w_meas)
            r_highTime <= r_hcnt;
      end
   end

   assign high_time = r_highTime;
`else
   assign high_time = '0;
`endif

   assign period  = r_period;
   assign valid   = r_valid;
   assign timeout = r_timeout;
   assign busy    = (r_state == MEASURE);

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: waves push expected period/high pairs, a negedge
// monitor pops them on every valid pulse. Honours FREQ_METER_DUTY_EN for high_time.
module tb_freq_meter;

   localparam int W    = 16;
   localparam int TO   = 100;
   localparam int SYNC = 2;

   logic         clk_in = 1'b0;
   logic         reset  = 1'b1;
   logic         sig_in = 1'b0;
   logic         enable = 1'b0;
   logic [W-1:0] period;
   logic [W-1:0] high_time;
   logic         valid;
   logic         timeout;
   logic         busy;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] expPeriod[$];
   logic [W-1:0] expHigh[$];
   logic         prevValid = 1'b0;
   logic         sawTimeout = 1'b0;

   freq_meter #(.CNT_W(W), .TIMEOUT(TO), .SYNC_STAGES(SYNC)) dut (
      .clk_in(clk_in), .reset(reset), .sig_in(sig_in), .enable(enable),
      .period(period), .high_time(high_time), .valid(valid),
      .timeout(timeout), .busy(busy)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [W-1:0] highOf(int h);
`ifdef FREQ_METER_DUTY_EN
      return W'(h);
`else
      return '0;
`endif
   endfunction

   // Monitor: every valid pulse must match the oldest expected measurement.
   always @(negedge clk_in) begin
      if (!reset) begin
         if (timeout) sawTimeout = 1'b1;
         if (valid) begin
            total++;
            if (prevValid) begin
               bad++;
               $display("[TB] FAIL valid_width: valid high two cycles in a row, required one");
            end else if (expPeriod.size() == 0) begin
               bad++;
               $display("[TB] FAIL unexpected_valid: period=%0d high=%0d, required no valid",
                        period, high_time);
            end else begin
               logic [W-1:0] ep, eh;
               ep = expPeriod.pop_front();
               eh = expHigh.pop_front();
               if (period !== ep || high_time !== eh) begin
                  bad++;
                  $display("[TB] FAIL measurement: period=%0d high=%0d, required period=%0d high=%0d",
                           period, high_time, ep, eh);
               end
            end
         end
         prevValid = valid;
      end else begin
         prevValid = 1'b0;
      end
   end

   task automatic cycle(int n);
      repeat (n) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   task automatic gen_wave(int h, int l, int n);
      for (int i = 0; i < n; i++) begin
         sig_in = 1'b1;
         cycle(h);
         sig_in = 1'b0;
         cycle(l);
      end
   endtask

   task automatic push_exp(int p, int h, int n);
      for (int i = 0; i < n; i++) begin
         expPeriod.push_back(W'(p));
         expHigh.push_back(highOf(h));
      end
   endtask

   task automatic rearm();
      enable = 1'b0;
      cycle(3);
      enable = 1'b1;
      cycle(3);
   endtask

   task automatic check_drained(string name);
      total++;
      if (expPeriod.size() != 0) begin
         bad++;
         $display("[TB] FAIL %s_pending: %0d expected valids missing, required 0", name, expPeriod.size());
      end
      expPeriod.delete();
      expHigh.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cycle(3);
      total++;
      if (period !== '0 || high_time !== '0 || valid !== 1'b0 || timeout !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_state: p=%0d h=%0d v=%b t=%b b=%b, required all 0",
                  period, high_time, valid, timeout, busy);
      end
      reset = 1'b0;
      cycle(2);
   endtask

   task automatic test_div10();
      rearm();
      push_exp(10, 5, 5);
      gen_wave(5, 5, 6);
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL div10_busy: busy=%b, required 1", busy);
      end
      check_drained("div10");
   endtask

   task automatic test_duty();
      rearm();
      push_exp(10, 3, 2);
      gen_wave(3, 7, 3);
      check_drained("duty");
   endtask

   task automatic test_timeout();
      int n;
      logic [W-1:0] held;
      rearm();
      held = period;
      sig_in = 1'b1;
      n = 0;
      while (n < 300 && timeout !== 1'b1) begin
         cycle(1);
         n++;
         if (n == 5) sig_in = 1'b0;
      end
      sig_in = 1'b0;
      total++;
      if (n !== TO + SYNC + 1) begin
         bad++;
         $display("[TB] FAIL timeout_latency: timeout after %0d cycles, required %0d", n, TO + SYNC + 1);
      end
      total++;
      if (busy !== 1'b0 || period !== held) begin
         bad++;
         $display("[TB] FAIL timeout_state: busy=%b period=%0d, required busy=0 period=%0d", busy, period, held);
      end
      cycle(5);
      push_exp(20, 10, 2);
      gen_wave(10, 10, 3);
      total++;
      if (timeout !== 1'b0) begin
         bad++;
         $display("[TB] FAIL timeout_clear: timeout=%b, required 0", timeout);
      end
      check_drained("timeout");
   endtask

   task automatic test_boundary();
      rearm();
      sawTimeout = 1'b0;
      push_exp(TO, TO / 2, 2);
      gen_wave(TO / 2, TO / 2, 3);
      total++;
      if (sawTimeout !== 1'b0) begin
         bad++;
         $display("[TB] FAIL boundary_timeout: timeout seen=%b, required 0", sawTimeout);
      end
      enable = 1'b0;
      cycle(1);
      check_drained("boundary");
   endtask

   task automatic test_enable();
      rearm();
      push_exp(10, 4, 2);
      gen_wave(4, 6, 3);
      enable = 1'b0;
      gen_wave(2, 2, 3);
      total++;
      if (busy !== 1'b0 || timeout !== 1'b0 || period !== W'(10) || high_time !== highOf(4)) begin
         bad++;
         $display("[TB] FAIL enable_hold: b=%b t=%b p=%0d h=%0d, required b=0 t=0 p=10 h=%0d",
                  busy, timeout, period, high_time, highOf(4));
      end
      enable = 1'b1;
      cycle(3);
      push_exp(4, 2, 2);
      gen_wave(2, 2, 3);
      check_drained("enable");
   endtask

   task automatic test_reset_mid();
      rearm();
      push_exp(10, 3, 1);
      gen_wave(3, 7, 2);
      sig_in = 1'b1;
      cycle(2);
      reset = 1'b1;
      #1;
      total++;
      if (period !== '0 || high_time !== '0 || valid !== 1'b0 || timeout !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_async: p=%0d h=%0d v=%b t=%b b=%b, required all 0",
                  period, high_time, valid, timeout, busy);
      end
      sig_in = 1'b0;
      cycle(3);
      reset = 1'b0;
      cycle(3);
      push_exp(10, 3, 2);
      gen_wave(3, 7, 3);
      check_drained("reset_mid");
   endtask

   initial begin
      test_reset();
      test_div10();
      test_duty();
      test_timeout();
      test_boundary();
      test_enable();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
